// File: rtl/cdc_hs_tx_pkg.sv
// Shared definitions for the source side of the 2-phase CDC handshake.
package cdc_hs_tx_pkg;

    typedef enum logic {
        StIdle    = 1'b0,
        StWaitAck = 1'b1
    } tx_state_e;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultNumStages = 2;

endpackage

// File: rtl/cdc_ack_sync.sv
// Multi-flop synchronizer that brings the destination's acknowledge level into the source clock.
module cdc_ack_sync #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic ack_i,
    output logic ack_s_o
);

    logic [NUM_STAGES-1:0] sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], ack_i};
        end
    end

    assign ack_s_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a 2-phase (toggle) request/acknowledge handshake carrying one word per transfer.
module cdc_hs_tx
    import cdc_hs_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned NUM_STAGES = DefaultNumStages
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] SRC_DATA,
    input  logic                  SRC_VALID,
    output logic                  SRC_READY,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_REQ,
    input  logic                  RX_ACK,
    output logic                  DONE,
    output logic                  PROTO_ERR
);

    tx_state_e             state_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_req_q;
    logic                  done_q;
    logic                  proto_err_q;
    logic                  ack_s;

    cdc_ack_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_ack_sync (
        .CLK    (CLK),
        .RST    (RST),
        .ack_i  (RX_ACK),
        .ack_s_o(ack_s)
    );

    // A transfer is complete once the synchronized ack level catches up with the request level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            tx_data_q   <= '0;
            tx_req_q    <= 1'b0;
            done_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ack_s != tx_req_q) begin
                        proto_err_q <= 1'b1;
                    end
                    if (SRC_VALID) begin
                        tx_data_q <= SRC_DATA;
                        tx_req_q  <= ~tx_req_q;
                        state_q   <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (ack_s == tx_req_q) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign SRC_READY = (state_q == StIdle);
    assign TX_DATA   = tx_data_q;
    assign TX_REQ    = tx_req_q;
    assign DONE      = done_q;
    assign PROTO_ERR = proto_err_q;

endmodule

// File: doc/cdc_hs_tx.md
CDC_HS_TX -- requirements
Module: cdc_hs_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the transferred word.
REQ-002 Parameter NUM_STAGES, default 2, minimum 2: flop stages in the acknowledge synchronizer.
REQ-003 CLK  input  1: source-domain clock, all state on rising edge.
REQ-004 RST  input  1: reset, asynchronous, active-low.
REQ-005 SRC_DATA  input  DATA_WIDTH: word offered by the source-domain logic.
REQ-006 SRC_VALID  input  1: SRC_DATA is valid this cycle.
REQ-007 SRC_READY  output  1: block can accept a word this cycle.
REQ-008 TX_DATA  output  DATA_WIDTH: registered word to the destination domain, stable while a transfer is pending.
REQ-009 TX_REQ  output  1: registered 2-phase (toggle) request level to the destination domain.
REQ-010 RX_ACK  input  1: asynchronous 2-phase acknowledge level from the destination domain.
REQ-011 DONE  output  1: single-cycle pulse when a transfer is acknowledged.
REQ-012 PROTO_ERR  output  1: sticky flag for an acknowledge toggle with no request outstanding.

Function
REQ-013 RX_ACK SHALL pass through a NUM_STAGES-flop synchronizer; ack_s (last stage) is the only RX_ACK-derived signal used.
REQ-014 FSM SHALL have two states: IDLE and WAIT_ACK.
REQ-015 SRC_READY SHALL equal (state == IDLE), combinationally.
REQ-016 In IDLE with SRC_VALID=1: TX_DATA <= SRC_DATA, TX_REQ <= ~TX_REQ, state -> WAIT_ACK, on the same edge.
REQ-017 In IDLE with SRC_VALID=0: all outputs hold.
REQ-018 In WAIT_ACK: TX_DATA and TX_REQ SHALL hold; SRC_VALID ignored.
REQ-019 In WAIT_ACK with ack_s == TX_REQ: state -> IDLE, DONE = 1 for exactly that next cycle.
REQ-020 SRC_READY SHALL be high the cycle after DONE-triggering edge; back-to-back accept allowed on that cycle.
REQ-021 TX_DATA SHALL change only on an accept edge, so data is stable at least one cycle before and for the whole time after each TX_REQ toggle until acknowledge.
REQ-022 Minimum accept-to-accept period SHALL be NUM_STAGES + 2 source cycles plus receiver latency; no throughput beyond one word per handshake.
REQ-023 In IDLE with ack_s != TX_REQ: PROTO_ERR <= 1 and remains set until reset; FSM state unaffected.
REQ-024 TX_REQ toggle polarity SHALL wrap freely (0->1->0); no count limit.

Reset
REQ-025 On RST low: state = IDLE, TX_REQ = 0, TX_DATA = 0, DONE = 0, PROTO_ERR = 0, all synchronizer flops = 0.
REQ-026 Reset mid-transfer SHALL abandon the transfer; destination side SHALL be reset concurrently (system requirement) so levels realign at 0.
REQ-027 After RST release, SRC_READY SHALL be 1 on the first clock.

Structure
REQ-028 Shared package SHALL hold FSM state encoding (IDLE=0, WAIT_ACK=1) and default DATA_WIDTH/NUM_STAGES constants.
REQ-029 Acknowledge synchronizer SHALL be a sub-module cdc_ack_sync (1-bit, NUM_STAGES param, same reset); FSM and data register stay in cdc_hs_tx.
REQ-030 No combinational path from RX_ACK to any output.

Verification
REQ-031 Single transfer: SRC_DATA=0xA5, SRC_VALID 1 cycle; model echoes TX_REQ to RX_ACK after 3 cycles -> TX_DATA=0xA5, TX_REQ=1, DONE pulse at ack+NUM_STAGES+1, SRC_READY back high.
REQ-032 Back-to-back: SRC_VALID held, words 0x01,0x02,0x03 -> each accepted only when SRC_READY=1, TX_REQ toggles 1,0,1, three DONE pulses, TX_DATA never changes in WAIT_ACK.
REQ-033 Busy drop: SRC_DATA changed to 0xFF during WAIT_ACK -> TX_DATA stays 0x5A, no extra TX_REQ toggle.
REQ-034 Spurious ack: toggle RX_ACK while IDLE -> PROTO_ERR=1 after NUM_STAGES+1 cycles, stays 1 until RST.
REQ-035 Reset mid-op: assert RST during WAIT_ACK -> TX_REQ=0, TX_DATA=0, SRC_READY=1 after release, next transfer completes normally.
REQ-036 NUM_STAGES=3, DATA_WIDTH=16, random receiver delay 0-20 cycles, 1000 words -> received sequence equals sent sequence, PROTO_ERR stays 0.
